// File: rtl/id_ex_fwd_stage.sv
`default_nettype none
// ============================================================================
// Module      : id_ex_fwd_stage
// Description : ID/EX pipeline register with load-use hazard detection,
//               bubble insertion on stall or flush, EX-operand forwarding
//               selects from the EX/MEM and MEM/WB stages, and saturating
//               stall/flush event counters.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk, rst_n                      clock, asynchronous active-low reset
//   id_valid_i                      ID holds a real instruction
//   id_rs1_i, id_rs2_i, id_rd_i     ID register addresses
//   id_rd1_i, id_rd2_i              register-file read data
//   id_regwrite_i, id_memread_i     decoded controls
//   flush_i                         squash the ID instruction
//   mem_rd_i, mem_regwrite_i        EX/MEM destination / write enable
//   wb_rd_i, wb_regwrite_i          MEM/WB destination / write enable
//   ex_*_o                          registered fields presented to EX
//   fwd_a_o, fwd_b_o                operand mux selects (00 RF, 01 WB, 10 MEM)
//   stall_o                         hold PC and IF/ID this cycle
//   stall_cnt_o, flush_cnt_o        saturating event counters
// ============================================================================
module id_ex_fwd_stage #(
  parameter int WIDTH = 32,
  parameter int RW    = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             id_valid_i,
  input  logic [RW-1:0]    id_rs1_i,
  input  logic [RW-1:0]    id_rs2_i,
  input  logic [RW-1:0]    id_rd_i,
  input  logic [WIDTH-1:0] id_rd1_i,
  input  logic [WIDTH-1:0] id_rd2_i,
  input  logic             id_regwrite_i,
  input  logic             id_memread_i,
  input  logic             flush_i,
  input  logic [RW-1:0]    mem_rd_i,
  input  logic             mem_regwrite_i,
  input  logic [RW-1:0]    wb_rd_i,
  input  logic             wb_regwrite_i,
  output logic             ex_valid_o,
  output logic             ex_regwrite_o,
  output logic             ex_memread_o,
  output logic [RW-1:0]    ex_rs1_o,
  output logic [RW-1:0]    ex_rs2_o,
  output logic [RW-1:0]    ex_rd_o,
  output logic [WIDTH-1:0] ex_rd1_o,
  output logic [WIDTH-1:0] ex_rd2_o,
  output logic [1:0]       fwd_a_o,
  output logic [1:0]       fwd_b_o,
  output logic             stall_o,
  output logic [15:0]      stall_cnt_o,
  output logic [15:0]      flush_cnt_o
);

  localparam logic [15:0] c_CNT_MAX  = 16'hFFFF;
  localparam logic [1:0]  c_FWD_RF   = 2'b00;
  localparam logic [1:0]  c_FWD_WB   = 2'b01;
  localparam logic [1:0]  c_FWD_MEM  = 2'b10;
  localparam logic [RW-1:0] c_X0     = '0;

  // Pipeline register state
  logic             ex_valid_q,    ex_valid_d;
  logic             ex_regwrite_q, ex_regwrite_d;
  logic             ex_memread_q,  ex_memread_d;
  logic [RW-1:0]    ex_rs1_q,      ex_rs1_d;
  logic [RW-1:0]    ex_rs2_q,      ex_rs2_d;
  logic [RW-1:0]    ex_rd_q,       ex_rd_d;
  logic [WIDTH-1:0] ex_rd1_q,      ex_rd1_d;
  logic [WIDTH-1:0] ex_rd2_q,      ex_rd2_d;
  logic [15:0]      stall_cnt_q,   stall_cnt_d;
  logic [15:0]      flush_cnt_q,   flush_cnt_d;

  logic w_hazard;
  logic w_stall;
  logic w_bubble;

  // Load-use: the load in EX writes a register the ID instruction reads.
  // x0 is never a real destination, so it cannot create a hazard.
  always_comb begin
    w_hazard = ex_valid_q && ex_memread_q && (ex_rd_q != c_X0) && id_valid_i &&
               ((ex_rd_q == id_rs1_i) || (ex_rd_q == id_rs2_i));
    // A squashed instruction never needs to wait for its operands.
    w_stall  = w_hazard && !flush_i;
    w_bubble = flush_i || w_stall;
  end

  // Next-state for the stage register: bubble zeroes every field, otherwise
  // the ID fields load with controls qualified by id_valid_i.
  always_comb begin
    ex_valid_d    = 1'b0;
    ex_regwrite_d = 1'b0;
    ex_memread_d  = 1'b0;
    ex_rs1_d      = '0;
    ex_rs2_d      = '0;
    ex_rd_d       = '0;
    ex_rd1_d      = '0;
    ex_rd2_d      = '0;
    if (!w_bubble) begin
      ex_valid_d    = id_valid_i;
      ex_regwrite_d = id_regwrite_i && id_valid_i;
      ex_memread_d  = id_memread_i && id_valid_i;
      ex_rs1_d      = id_rs1_i;
      ex_rs2_d      = id_rs2_i;
      ex_rd_d       = id_rd_i;
      ex_rd1_d      = id_rd1_i;
      ex_rd2_d      = id_rd2_i;
    end
  end

  // Saturating event counters
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (w_stall && (stall_cnt_q != c_CNT_MAX)) begin
      stall_cnt_d = stall_cnt_q + 16'd1;
    end
    if (flush_i && (flush_cnt_q != c_CNT_MAX)) begin
      flush_cnt_d = flush_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_valid_q    <= 1'b0;
      ex_regwrite_q <= 1'b0;
      ex_memread_q  <= 1'b0;
      ex_rs1_q      <= '0;
      ex_rs2_q      <= '0;
      ex_rd_q       <= '0;
      ex_rd1_q      <= '0;
      ex_rd2_q      <= '0;
      stall_cnt_q   <= '0;
      flush_cnt_q   <= '0;
    end else begin
      ex_valid_q    <= ex_valid_d;
      ex_regwrite_q <= ex_regwrite_d;
      ex_memread_q  <= ex_memread_d;
      ex_rs1_q      <= ex_rs1_d;
      ex_rs2_q      <= ex_rs2_d;
      ex_rd_q       <= ex_rd_d;
      ex_rd1_q      <= ex_rd1_d;
      ex_rd2_q      <= ex_rd2_d;
      stall_cnt_q   <= stall_cnt_d;
      flush_cnt_q   <= flush_cnt_d;
    end
  end

  // Forwarding selects. MEM is the younger result, so it has priority over
  // WB. An empty EX slot always reads the register file.
  always_comb begin
    fwd_a_o = c_FWD_RF;
    fwd_b_o = c_FWD_RF;
    if (ex_valid_q) begin
      if (mem_regwrite_i && (mem_rd_i != c_X0) && (mem_rd_i == ex_rs1_q)) begin
        fwd_a_o = c_FWD_MEM;
      end else if (wb_regwrite_i && (wb_rd_i != c_X0) && (wb_rd_i == ex_rs1_q)) begin
        fwd_a_o = c_FWD_WB;
      end
      if (mem_regwrite_i && (mem_rd_i != c_X0) && (mem_rd_i == ex_rs2_q)) begin
        fwd_b_o = c_FWD_MEM;
      end else if (wb_regwrite_i && (wb_rd_i != c_X0) && (wb_rd_i == ex_rs2_q)) begin
        fwd_b_o = c_FWD_WB;
      end
    end
  end

  assign stall_o       = w_stall;
  assign ex_valid_o    = ex_valid_q;
  assign ex_regwrite_o = ex_regwrite_q;
  assign ex_memread_o  = ex_memread_q;
  assign ex_rs1_o      = ex_rs1_q;
  assign ex_rs2_o      = ex_rs2_q;
  assign ex_rd_o       = ex_rd_q;
  assign ex_rd1_o      = ex_rd1_q;
  assign ex_rd2_o      = ex_rd2_q;
  assign stall_cnt_o   = stall_cnt_q;
  assign flush_cnt_o   = flush_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_id_ex_fwd_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_id_ex_fwd_stage
// Description : Self-checking bench for id_ex_fwd_stage: forwarding table,
//               directed hazard/flush/reset/saturation sequences and random
//               traffic against a behavioural model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_id_ex_fwd_stage;

  localparam int WIDTH = 32;
  localparam int RW    = 5;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             id_valid_i;
  logic [RW-1:0]    id_rs1_i, id_rs2_i, id_rd_i;
  logic [WIDTH-1:0] id_rd1_i, id_rd2_i;
  logic             id_regwrite_i, id_memread_i, flush_i;
  logic [RW-1:0]    mem_rd_i, wb_rd_i;
  logic             mem_regwrite_i, wb_regwrite_i;
  logic             ex_valid_o, ex_regwrite_o, ex_memread_o;
  logic [RW-1:0]    ex_rs1_o, ex_rs2_o, ex_rd_o;
  logic [WIDTH-1:0] ex_rd1_o, ex_rd2_o;
  logic [1:0]       fwd_a_o, fwd_b_o;
  logic             stall_o;
  logic [15:0]      stall_cnt_o, flush_cnt_o;

  id_ex_fwd_stage #(.WIDTH(WIDTH), .RW(RW)) dut (
    .clk(clk), .rst_n(rst_n),
    .id_valid_i(id_valid_i), .id_rs1_i(id_rs1_i), .id_rs2_i(id_rs2_i), .id_rd_i(id_rd_i),
    .id_rd1_i(id_rd1_i), .id_rd2_i(id_rd2_i),
    .id_regwrite_i(id_regwrite_i), .id_memread_i(id_memread_i), .flush_i(flush_i),
    .mem_rd_i(mem_rd_i), .mem_regwrite_i(mem_regwrite_i),
    .wb_rd_i(wb_rd_i), .wb_regwrite_i(wb_regwrite_i),
    .ex_valid_o(ex_valid_o), .ex_regwrite_o(ex_regwrite_o), .ex_memread_o(ex_memread_o),
    .ex_rs1_o(ex_rs1_o), .ex_rs2_o(ex_rs2_o), .ex_rd_o(ex_rd_o),
    .ex_rd1_o(ex_rd1_o), .ex_rd2_o(ex_rd2_o),
    .fwd_a_o(fwd_a_o), .fwd_b_o(fwd_b_o), .stall_o(stall_o),
    .stall_cnt_o(stall_cnt_o), .flush_cnt_o(flush_cnt_o)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef struct {
    bit         valid, regwrite, memread;
    int         rs1, rs2, rd;
    logic [WIDTH-1:0] d1, d2;
  } ex_slot_t;

  ex_slot_t m_ex;
  int       m_scnt, m_fcnt;

  function automatic void model_reset();
    m_ex = '{default: 0};
    m_scnt = 0;
    m_fcnt = 0;
  endfunction

  // Does the ID instruction need a value the EX load has not fetched yet?
  function automatic bit model_stall();
    bit reads_load;
    reads_load = (m_ex.rd == int'(id_rs1_i)) || (m_ex.rd == int'(id_rs2_i));
    return m_ex.valid && m_ex.memread && m_ex.rd != 0 && id_valid_i && reads_load && !flush_i;
  endfunction

  // Where should an EX operand come from, given its source register?
  function automatic int model_fwd(input int src);
    if (!m_ex.valid || src == 0) return 0;
    if (mem_regwrite_i && int'(mem_rd_i) == src) return 2;
    if (wb_regwrite_i && int'(wb_rd_i) == src) return 1;
    return 0;
  endfunction

  function automatic void model_clock();
    bit st;
    st = model_stall();
    if (st && m_scnt < 65535) m_scnt++;
    if (flush_i && m_fcnt < 65535) m_fcnt++;
    if (st || flush_i) begin
      m_ex = '{default: 0};
    end else begin
      m_ex.valid    = id_valid_i;
      m_ex.regwrite = id_regwrite_i && id_valid_i;
      m_ex.memread  = id_memread_i && id_valid_i;
      m_ex.rs1 = int'(id_rs1_i);
      m_ex.rs2 = int'(id_rs2_i);
      m_ex.rd  = int'(id_rd_i);
      m_ex.d1  = id_rd1_i;
      m_ex.d2  = id_rd2_i;
    end
  endfunction

  task automatic check_all(input string tag);
    check({tag, ".stall"},    stall_o,       model_stall());
    check({tag, ".fwd_a"},    fwd_a_o,       model_fwd(m_ex.rs1));
    check({tag, ".fwd_b"},    fwd_b_o,       model_fwd(m_ex.rs2));
    check({tag, ".valid"},    ex_valid_o,    m_ex.valid);
    check({tag, ".regwrite"}, ex_regwrite_o, m_ex.regwrite);
    check({tag, ".memread"},  ex_memread_o,  m_ex.memread);
    check({tag, ".rs1"},      ex_rs1_o,      m_ex.rs1);
    check({tag, ".rs2"},      ex_rs2_o,      m_ex.rs2);
    check({tag, ".rd"},       ex_rd_o,       m_ex.rd);
    check({tag, ".rd1"},      ex_rd1_o,      m_ex.d1);
    check({tag, ".rd2"},      ex_rd2_o,      m_ex.d2);
    check({tag, ".scnt"},     stall_cnt_o,   m_scnt);
    check({tag, ".fcnt"},     flush_cnt_o,   m_fcnt);
  endtask

  // One clock: model advances with the same inputs the DUT samples.
  task automatic step();
    @(posedge clk);
    if (rst_n) model_clock(); else model_reset();
    @(negedge clk);
  endtask

  task automatic set_id(input bit v, input int rs1, input int rs2, input int rd,
                        input bit rw, input bit mr);
    id_valid_i    = v;
    id_rs1_i      = RW'(rs1);
    id_rs2_i      = RW'(rs2);
    id_rd_i       = RW'(rd);
    id_regwrite_i = rw;
    id_memread_i  = mr;
    id_rd1_i      = $urandom;
    id_rd2_i      = $urandom;
  endtask

  // ---------------- forwarding vector table ----------------
  typedef struct {
    bit        v;
    bit [4:0]  rs1, rs2, mrd;
    bit        mwe;
    bit [4:0]  wrd;
    bit        wwe;
    bit [1:0]  ea, eb;
  } fwd_vec_t;

  fwd_vec_t fvec[$];

  initial begin
    int s0, f0;
    fvec = '{
      '{1'b1, 5'd3,  5'd4,  5'd3,  1'b1, 5'd3,  1'b1, 2'b10, 2'b00},
      '{1'b1, 5'd3,  5'd4,  5'd3,  1'b0, 5'd3,  1'b1, 2'b01, 2'b00},
      '{1'b1, 5'd0,  5'd0,  5'd0,  1'b1, 5'd0,  1'b1, 2'b00, 2'b00},
      '{1'b1, 5'd7,  5'd7,  5'd7,  1'b1, 5'd2,  1'b1, 2'b10, 2'b10},
      '{1'b1, 5'd1,  5'd2,  5'd2,  1'b1, 5'd1,  1'b1, 2'b01, 2'b10},
      '{1'b1, 5'd5,  5'd6,  5'd5,  1'b0, 5'd6,  1'b0, 2'b00, 2'b00},
      '{1'b1, 5'd9,  5'd9,  5'd1,  1'b1, 5'd9,  1'b1, 2'b01, 2'b01},
      '{1'b1, 5'd31, 5'd30, 5'd31, 1'b1, 5'd30, 1'b1, 2'b10, 2'b01},
      '{1'b0, 5'd3,  5'd3,  5'd3,  1'b1, 5'd3,  1'b1, 2'b00, 2'b00}
    };

    // Reset state
    rst_n = 1'b0;
    set_id(0, 0, 0, 0, 0, 0);
    flush_i = 0; mem_rd_i = 0; mem_regwrite_i = 0; wb_rd_i = 0; wb_regwrite_i = 0;
    model_reset();
    #1;
    check("reset.valid", ex_valid_o, 0);
    check("reset.stall", stall_o, 0);
    check("reset.scnt", stall_cnt_o, 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1 check_all("reset");

    // Forwarding table
    foreach (fvec[i]) begin
      mem_regwrite_i = 0; wb_regwrite_i = 0;
      set_id(fvec[i].v, fvec[i].rs1, fvec[i].rs2, 8, 1, 0);
      step();
      mem_rd_i = fvec[i].mrd; mem_regwrite_i = fvec[i].mwe;
      wb_rd_i  = fvec[i].wrd; wb_regwrite_i  = fvec[i].wwe;
      #1;
      check($sformatf("fwdtab%0d.a", i), fwd_a_o, fvec[i].ea);
      check($sformatf("fwdtab%0d.b", i), fwd_b_o, fvec[i].eb);
    end
    mem_regwrite_i = 0; wb_regwrite_i = 0;

    // Load-use: lw x5 in EX, add reads x5 as rs2
    set_id(1, 1, 0, 5, 1, 1);
    step();
    s0 = m_scnt;
    set_id(1, 2, 5, 6, 1, 0);
    #1 check("lu.stall", stall_o, 1);
    step();
    check("lu.bubble", ex_valid_o, 0);
    check("lu.scnt", stall_cnt_o, s0 + 1);
    check("lu.stall_drop", stall_o, 0);
    step();
    check("lu.add_valid", ex_valid_o, 1);
    check("lu.add_rd", ex_rd_o, 6);
    check("lu.add_rs2", ex_rs2_o, 5);

    // Load to x0 never stalls
    set_id(1, 1, 0, 0, 1, 1);
    step();
    set_id(1, 0, 0, 3, 1, 0);
    #1 check("x0.stall", stall_o, 0);
    check_all("x0");

    // Flush and hazard in the same cycle
    set_id(1, 1, 0, 5, 1, 1);
    step();
    s0 = m_scnt; f0 = m_fcnt;
    set_id(1, 5, 0, 7, 1, 0);
    flush_i = 1;
    #1 check("fh.stall", stall_o, 0);
    step();
    flush_i = 0;
    check("fh.bubble", ex_valid_o, 0);
    check("fh.fcnt", flush_cnt_o, f0 + 1);
    check("fh.scnt", stall_cnt_o, s0);

    // Async reset during a stall
    set_id(1, 1, 0, 5, 1, 1);
    step();
    set_id(1, 5, 0, 9, 1, 0);
    mem_rd_i = 5; mem_regwrite_i = 1;
    #1 check("ar.stall_pre", stall_o, 1);
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    check("ar.valid", ex_valid_o, 0);
    check("ar.stall", stall_o, 0);
    check("ar.fwd_a", fwd_a_o, 0);
    check("ar.scnt", stall_cnt_o, 0);
    check("ar.fcnt", flush_cnt_o, 0);
    @(negedge clk);
    rst_n = 1'b1;
    mem_regwrite_i = 0;
    step();
    check("ar.load_valid", ex_valid_o, 1);
    check("ar.load_rd", ex_rd_o, 9);
    check("ar.load_rs1", ex_rs1_o, 5);

    // Stall-counter saturation from a preloaded value
    force dut.stall_cnt_q = 16'hFFFE;
    #1 release dut.stall_cnt_q;
    m_scnt = 32'hFFFE;
    set_id(1, 5, 0, 5, 1, 1);
    for (int k = 0; k < 6; k++) begin
      step();
      check_all("sat");
    end
    check("sat.final", stall_cnt_o, 16'hFFFF);

    // Random traffic against the model
    for (int k = 0; k < 1500; k++) begin
      set_id($urandom_range(0, 3) != 0, $urandom_range(0, 3), $urandom_range(0, 3),
             $urandom_range(0, 3), $urandom_range(0, 1), $urandom_range(0, 2) == 0);
      flush_i        = $urandom_range(0, 7) == 0;
      mem_rd_i       = RW'($urandom_range(0, 3));
      mem_regwrite_i = $urandom_range(0, 1);
      wb_rd_i        = RW'($urandom_range(0, 3));
      wb_regwrite_i  = $urandom_range(0, 1);
      #1 check_all("rnd");
      step();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/id_ex_fwd_stage.md
ID_EX_FWD_STAGE -- requirements
Module: id_ex_fwd_stage

Interface
REQ-001 Parameter WIDTH, default 32, operand data width.
REQ-002 Parameter RW, default 5, register-address width.
REQ-003 clk  in  1  single clock, all state on rising edge.
REQ-004 rst_n  in  1  reset, asynchronous, active-low.
REQ-005 id_valid  in  1  ID stage holds a real instruction.
REQ-006 id_rs1, id_rs2, id_rd  in  RW each  source/destination register addresses.
REQ-007 id_rd1, id_rd2  in  WIDTH each  register-file read data.
REQ-008 id_regwrite, id_memread  in  1 each  decoded controls.
REQ-009 flush  in  1  branch/jump resolved taken in EX; squash ID instruction.
REQ-010 mem_rd  in  RW, mem_regwrite  in  1  EX/MEM destination and write enable.
REQ-011 wb_rd  in  RW, wb_regwrite  in  1  MEM/WB destination and write enable.
REQ-012 ex_valid, ex_regwrite, ex_memread  out  1 each  registered controls to EX.
REQ-013 ex_rs1, ex_rs2, ex_rd  out  RW each; ex_rd1, ex_rd2  out  WIDTH each  registered fields.
REQ-014 fwd_a, fwd_b  out  2 each  select for EX operand 3:1 muxes.
REQ-015 stall  out  1  hold PC and IF/ID register this cycle.
REQ-016 stall_cnt, flush_cnt  out  16 each  event counters.

Function
REQ-017 Register stage SHALL load on every rising clk edge; no enable other than bubble insertion below.
REQ-018 Load-use hazard SHALL be: ex_valid & ex_memread & ex_rd!=0 & id_valid & (ex_rd==id_rs1 | ex_rd==id_rs2).
REQ-019 stall SHALL be combinational = hazard & !flush (flush wins; squashed instruction never stalls).
REQ-020 Bubble condition SHALL be flush | stall; on bubble the stage loads ex_valid=0, ex_regwrite=0, ex_memread=0, all address/data fields 0.
REQ-021 Otherwise the stage SHALL load all id_* fields; ex_regwrite/ex_memread load id_regwrite&id_valid / id_memread&id_valid.
REQ-022 Latency ID->EX SHALL be exactly 1 cycle; a stalled instruction appears in EX one cycle after stall deasserts.
REQ-023 fwd_a SHALL be combinational from registered ex_rs1: 2'b10 if mem_regwrite & mem_rd!=0 & mem_rd==ex_rs1; else 2'b01 if wb_regwrite & wb_rd!=0 & wb_rd==ex_rs1; else 2'b00.
REQ-024 fwd_b SHALL follow REQ-023 using ex_rs2.
REQ-025 Encoding SHALL be 00 = register-file data, 01 = WB result, 10 = MEM result; 11 SHALL never be driven.
REQ-026 When ex_valid=0, fwd_a and fwd_b SHALL be 2'b00.
REQ-027 Register 0 SHALL never be a forwarding or hazard source.
REQ-028 stall_cnt SHALL increment by 1 each cycle stall=1, saturating at 16'hFFFF.
REQ-029 flush_cnt SHALL increment by 1 each cycle flush=1, saturating at 16'hFFFF.
REQ-030 Consecutive load-use stalls SHALL not occur: after one bubble ex_memread=0, so stall drops the next cycle.

Reset
REQ-031 rst_n=0 SHALL immediately (without clk) force all registered outputs and both counters to 0; hence stall=0, fwd_a=fwd_b=2'b00.
REQ-032 Reset assertion mid-stall SHALL discard the in-flight instruction; first edge after release loads ID normally.

Verification
REQ-033 Load-use: EX holds lw x5 (ex_memread=1, ex_rd=5), ID has id_rs2=5, id_valid=1 -> stall=1 that cycle, next edge ex_valid=0, stall_cnt=1, following cycle stall=0 and add loaded.
REQ-034 Double forward: ex_rs1=3, mem_rd=3, wb_rd=3, both regwrite=1 -> fwd_a=2'b10; mem_regwrite=0 -> fwd_a=2'b01.
REQ-035 x0: ex_rs1=0, mem_rd=0, mem_regwrite=1 -> fwd_a=2'b00; load to x0 with id_rs1=0 -> stall=0.
REQ-036 Flush+hazard same cycle: hazard true, flush=1 -> stall=0, next edge bubble, flush_cnt+1, stall_cnt unchanged.
REQ-037 Saturation: preload 16'hFFFE, stall two cycles -> stall_cnt 16'hFFFF and held.
REQ-038 Async reset: rst_n low between edges with ex_valid=1 -> outputs 0 before next clk edge.
